// File: rtl/dco_freq_meter.sv
// Counts DCO rising edges over a gate window of system clocks and returns the count on a valid/ready port.
// Define DCO_FMEAS_AVG_EN to average four consecutive gate windows into the reported count.
module dco_freq_meter #(
    parameter int GATE_CYCLES = 200,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dco_in,
    input  logic             start,
    output logic             busy,
    output logic             valid,
    input  logic             ready,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam int GATE_W = $clog2(GATE_CYCLES + 1);
`ifdef DCO_FMEAS_AVG_EN
    localparam int ACC_W = CNT_W + 2;
`else
    localparam int ACC_W = CNT_W;
`endif
    localparam logic [GATE_W-1:0] SETTLE_LOAD = GATE_W'(2);
    localparam logic [GATE_W-1:0] GATE_LOAD   = GATE_W'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;

    state_t             state, state_nxt;
    logic [GATE_W-1:0]  gate_cnt;
    logic               sync_p0, sync_p1, hist_p2;
    logic               rise_p2;
    logic [ACC_W-1:0]   acc, acc_nxt;
    logic               ovf_acc, ovf_nxt;
    logic               gate_last, meas_last;

    function automatic logic [ACC_W-1:0] sat_inc(input logic [ACC_W-1:0] a, input logic inc);
        if (inc && (a != '1))
            return a + 1'b1;
        return a;
    endfunction

    // Stage p0/p1 resynchronise the asynchronous DCO, p2 holds history for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            hist_p2 <= 1'b0;
        end else begin
            sync_p0 <= dco_in;
            sync_p1 <= sync_p0;
            hist_p2 <= sync_p1;
        end
    end

    assign rise_p2   = sync_p1 & ~hist_p2;
    assign gate_last = (gate_cnt == '0);

`ifdef DCO_FMEAS_AVG_EN
    logic [1:0] win;

    always_ff @(posedge clk) begin
        if (!rst_n)
            win <= 2'd0;
        else if (state == SETTLE)
            win <= 2'd0;
        else if (state == MEASURE && gate_last)
            win <= win + 2'd1;
    end

    assign meas_last = gate_last && (win == 2'd3);
`else
    assign meas_last = gate_last;
`endif

    assign acc_nxt = (state == MEASURE) ? sat_inc(acc, rise_p2) : acc;
    assign ovf_nxt = ovf_acc | ((state == MEASURE) && (acc_nxt == '1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)     state_nxt = SETTLE;
            SETTLE:  if (gate_last) state_nxt = MEASURE;
            MEASURE: if (meas_last) state_nxt = DONE;
            DONE:    if (ready)     state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            gate_cnt <= '0;
            acc      <= '0;
            ovf_acc  <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        gate_cnt <= SETTLE_LOAD;
                        acc      <= '0;
                        ovf_acc  <= 1'b0;
                    end
                end
                SETTLE: begin
                    acc      <= '0;
                    ovf_acc  <= 1'b0;
                    gate_cnt <= gate_last ? GATE_LOAD : gate_cnt - 1'b1;
                end
                MEASURE: begin
                    acc      <= acc_nxt;
                    ovf_acc  <= ovf_nxt;
                    gate_cnt <= gate_last ? GATE_LOAD : gate_cnt - 1'b1;
                    // An edge landing in the final gate cycle is still part of the result
                    if (meas_last) begin
                        count    <= acc_nxt[ACC_W-1 -: CNT_W];
                        overflow <= ovf_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state == SETTLE) || (state == MEASURE);
    assign valid = (state == DONE);

endmodule

// File: tb/tb_dco_freq_meter.sv
// Randomised bench for dco_freq_meter: a synchronous DCO waveform model records every rising edge,
// and expected counts are derived from the edge log and the documented window timing.
module tb_dco_freq_meter;

    localparam int G  = 200;
    localparam int CW = 6;
`ifdef DCO_FMEAS_AVG_EN
    localparam int WINS = 4;
    localparam int ACCW = CW + 2;
`else
    localparam int WINS = 1;
    localparam int ACCW = CW;
`endif
    localparam int MAXC = 40000;

    logic          clk = 1'b0;
    logic          rst_n, start, ready, dco_in;
    logic          busy, valid, overflow;
    logic [CW-1:0] count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int hi_c = 0;
    int lo_c = 1;
    int prev_count = 0;
    int prev_ovf = 0;
    bit rises [0:MAXC-1];

    dco_freq_meter #(.GATE_CYCLES(G), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .dco_in(dco_in), .start(start), .busy(busy),
        .valid(valid), .ready(ready), .count(count), .overflow(overflow)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DCO waveform: hi_c cycles high, lo_c cycles low, changing at falling clock edges
    initial begin
        int ph;
        bit nv;
        ph = 0;
        dco_in = 1'b0;
        forever begin
            @(negedge clk);
            if (hi_c == 0) begin
                nv = 1'b0;
            end else begin
                nv = (ph < hi_c);
                ph = ph + 1;
                if (ph >= hi_c + lo_c) ph = 0;
            end
            if (nv && !dco_in && cyc + 1 < MAXC) rises[cyc+1] = 1'b1;
            dco_in = nv;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // An edge first sampled at clock k is counted at clock k+2; the gate spans clocks n+4 .. n+3+G*WINS
    function automatic void expect_result(input int n, output int ec, output int eo);
        int total;
        int accmax;
        int sat;
        total = 0;
        for (int k = n + 2; k <= n + 1 + G * WINS; k++) total += int'(rises[k]);
        accmax = (1 << ACCW) - 1;
        sat = (total > accmax) ? accmax : total;
        eo = (total >= accmax) ? 1 : 0;
        ec = sat >> (ACCW - CW);
    endfunction

    task automatic measure(input int hi, input int lo, input int hold, input bit poke);
        int n, bc, vc, ec, eo;
        hi_c = hi;
        lo_c = lo;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = cyc;
        check("busy_rise", busy, 1);
        check("count_hold", count, prev_count);
        check("ovf_hold", overflow, prev_ovf);
        bc = 1;
        vc = -1;
        for (int t = 0; t < G * WINS + 20; t++) begin
            @(negedge clk);
            if (valid) begin
                vc = cyc;
                break;
            end
            if (busy) bc++;
        end
        check("valid_latency", vc - n, 3 + G * WINS);
        check("busy_cycles", bc, 3 + G * WINS);
        check("busy_in_done", busy, 0);
        expect_result(n, ec, eo);
        check("count", count, ec);
        check("overflow", overflow, eo);
        prev_count = ec;
        prev_ovf = eo;
        for (int t = 0; t < hold; t++) begin
            if (poke && t == hold / 2) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        check("valid_held", valid, 1);
        check("count_held", count, ec);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check("valid_drop", valid, 0);
        check("busy_after_xfer", busy, 0);
        @(negedge clk);
        check("start_not_queued", busy, 0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        measure(3, 2, 0, 1'b0);   // 100 ns period at 20 ns clock
        measure(0, 1, 0, 1'b0);   // DCO stuck low
        measure(2, 1, 0, 1'b0);   // 60 ns period saturates the count
        measure(3, 2, 50, 1'b1);  // long back-pressure with a stray start in DONE

        // Reset in the middle of the gate window
        hi_c = 3;
        lo_c = 2;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = cyc;
        while (cyc < n + 103) @(negedge clk);
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mrst_busy", busy, 0);
        check("mrst_valid", valid, 0);
        check("mrst_count", count, 0);
        check("mrst_overflow", overflow, 0);
        prev_count = 0;
        prev_ovf = 0;
        measure(3, 2, 0, 1'b0);

        for (int i = 0; i < 8; i++)
            measure($urandom_range(1, 7), $urandom_range(1, 7), $urandom_range(0, 5), 1'($urandom_range(0, 1)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dco_freq_meter.md
# dco_freq_meter

On-chip frequency meter for the DCO output. The block is the receive-side counterpart of the DCO: it takes the oscillator's raw square wave, counts its rising edges over a fixed gate window of system clocks, and reports the count through a valid/ready result port. It sits beside the DCO inside `tt_um_dco` and supports code-to-frequency characterisation without external instruments.

## Interface
- `GATE_CYCLES`, 200: gate window length in `clk` cycles, ≥ 4.
- `CNT_W`, 16: edge-count width; result saturates at 2^CNT_W−1.

- `clk`  in  1  system clock, the only clock domain.
- `rst_n`  in  1  reset, synchronous, active-low.
- `dco_in`  in  1  DCO output, asynchronous to `clk`.
- `start`  in  1  single-cycle request for a measurement, sampled only in IDLE.
- `busy`  out  1  high in SETTLE and MEASURE.
- `valid`  out  1  result available.
- `ready`  in  1  consumer accepts the result.
- `count`  out  CNT_W  edges counted in the window, saturated.
- `overflow`  out  1  saturation occurred during the window.

## Operation
- Input path:
  - 2-flop synchronizer on `dco_in`, then one history flop.
  - A rising edge is `sync & ~hist`.
  - Measurable range is f_dco < f_clk/2. Above that the count is undefined but must not hang the FSM.
- FSM states IDLE, SETTLE, MEASURE, DONE:
  - IDLE → SETTLE on `start`. The edge counter and overflow clear.
  - SETTLE lasts exactly 3 cycles, so stale synchronizer data is flushed. Edges are not counted.
  - MEASURE lasts exactly GATE_CYCLES cycles. Each detected edge increments the counter. At 2^CNT_W−1 the counter holds and sets `overflow`.
  - MEASURE → DONE. The counter value is copied into `count` and `valid` rises.
  - DONE → IDLE in the cycle after `valid & ready`.
- `start` outside IDLE is ignored; it is not queued.
- `count` and `overflow` hold their value from the end of one measurement until the next MEASURE→DONE transition. They stay stable through IDLE and the next SETTLE/MEASURE.
- `valid` stays high and `count` stays stable until the handshake. A low `ready` never drops a result.
- Gate counter: width ceil(log2(GATE_CYCLES+1)). It reloads on entry to MEASURE.

## Timing
- Reset (`rst_n` low at a `clk` edge), effective that edge, from any state:
  - Forces IDLE.
  - `busy`=0, `valid`=0, `count`=0, `overflow`=0.
  - Clears the synchronizer, history flop and both counters.
  - Reset mid-MEASURE discards the partial count.
- Pipeline delays:
  - `dco_in` rising edge → counter increment: 3 cycles.
  - `start` accepted at edge N → `busy` high at N+1.
  - MEASURE occupies edges N+4 … N+3+GATE_CYCLES.
  - `valid` is high, with `busy` low, from N+4+GATE_CYCLES.
- Handshake:
  - Transfer happens at the edge where `valid & ready`.
  - `valid` is low the next cycle.
  - The earliest new `start` is sampled one cycle after the transfer, in IDLE.
- Overflow versus edge in the same cycle: once saturated, further edges have no effect. `overflow` is sticky for the window.
- Window boundary: an edge detected in the final MEASURE cycle is counted. An edge detected in the DONE cycle is not.

## Configuration
- `DCO_FMEAS_AVG_EN`
  - Defined:
    - MEASURE runs 4 consecutive gate windows, 4×GATE_CYCLES cycles total.
    - Edges accumulate into a CNT_W+2-bit accumulator, cleared on entry to MEASURE.
    - `count` = accumulator[CNT_W+1:2], i.e. the truncated mean.
    - `overflow` is set if the accumulator reaches 2^(CNT_W+2)−1; it then saturates and holds.
    - `valid` latency becomes N+4+4×GATE_CYCLES.
  - Undefined: single window as described above. The accumulator logic is absent.

## Test plan
- 50 MHz `clk`, GATE_CYCLES=200, `dco_in` period 100 ns; pulse `start` → `busy` 203 cycles, then `valid`=1, `count`=40±1, `overflow`=0.
- `dco_in` held 0; `start` → `valid` after 204 cycles, `count`=0, `overflow`=0.
- CNT_W=4, `dco_in` period 60 ns; `start` → `count`=15, `overflow`=1.
- `ready` held low 50 cycles after `valid`, plus `start` pulsed during DONE → `valid` and `count` stable, no new measurement; `ready`=1 → `valid`=0 next cycle, IDLE.
- `rst_n` low for 1 cycle at MEASURE cycle 100 → next cycle `busy`=0, `valid`=0, `count`=0; a fresh `start` yields `count`=40±1.
- With `DCO_FMEAS_AVG_EN`, `dco_in` period 100 ns → `valid` at start+804 cycles, `count`=40±1.
